// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID instruction queue.
package if_id_pkg;

  localparam int unsigned PcWDefault    = 8;
  localparam int unsigned InstrWDefault = 8;
  localparam logic [7:0]  NopInstr      = 8'h00;

  typedef struct packed {
    logic [PcWDefault-1:0]    pc;
    logic [InstrWDefault-1:0] instr;
  } if_id_entry_t;

endpackage

// File: rtl/fifo_ptr.sv
// FIFO pointer with an extra wrap bit above the index; clear beats increment.
module fifo_ptr #(
  parameter int unsigned IdxW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [IdxW:0] ptr_o
);

  logic [IdxW:0] ptr_d, ptr_q;

  // Power-of-two depth: plain binary increment wraps the index and toggles the wrap bit.
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + {{IdxW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry {pc, instr} FIFO between fetch and decode; NOP at the head when empty.
// Define IFQ_STATS_EN to add the stall_cycles / flush_count counters.
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int unsigned PC_W    = PcWDefault,
  parameter int unsigned INSTR_W = InstrWDefault,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    pc_out,
  output logic [INSTR_W-1:0] instr_out,
  output logic [CNT_W-1:0]   count
`ifdef IFQ_STATS_EN
  ,
  output logic [15:0]        stall_cycles,
  output logic [15:0]        flush_count
`endif
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        head;
  logic [IdxW:0] rd_ptr, wr_ptr;
  logic          empty, full, push, pop;

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[IdxW-1:0] == wr_ptr[IdxW-1:0]) && (rd_ptr[IdxW] != wr_ptr[IdxW]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid & in_ready & !flush;
  assign pop       = out_valid & out_ready & !flush;

  fifo_ptr #(
    .IdxW (IdxW)
  ) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (push),
    .clr_i (flush),
    .ptr_o (wr_ptr)
  );

  fifo_ptr #(
    .IdxW (IdxW)
  ) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (pop),
    .clr_i (flush),
    .ptr_o (rd_ptr)
  );

  // Storage is never reset; empty forces the outputs so stale contents stay hidden.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr[IdxW-1:0]] <= '{pc: pc, instr: instr_in};
    end
  end

  assign head      = mem_q[rd_ptr[IdxW-1:0]];
  assign pc_out    = empty ? '0 : head.pc;
  assign instr_out = empty ? INSTR_W'(NopInstr) : head.instr;
  assign count     = CNT_W'(wr_ptr - rd_ptr);

`ifdef IFQ_STATS_EN
  logic [15:0] stall_d, stall_q, flush_cnt_d, flush_cnt_q;

  always_comb begin
    stall_d     = stall_q;
    flush_cnt_d = flush_cnt_q;
    if (in_valid && !in_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
    if (flush && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_q     <= stall_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
Parametrised successor to the single-entry IF/ID pipeline register. It is a DEPTH-entry FIFO of {pc, instr} pairs between fetch and decode, with a valid/ready handshake on both sides. Fetch can run ahead of decode stalls. A flush from branch resolution discards all queued entries. Decode sees a NOP (all zeros) whenever the queue is empty.

Parameters:
PC_W, 8, width of the pc field
INSTR_W, 8, width of the instruction field
DEPTH, 4, number of entries; power of two, at least 2
CNT_W, $clog2(DEPTH)+1, width of the occupancy count

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset; when 0, clears the queue immediately
flush  in  1  synchronous flush; highest priority
in_valid  in  1  fetch presents a valid pc/instr pair
in_ready  out  1  queue can accept an entry this cycle
pc  in  PC_W  fetch pc
instr_in  in  INSTR_W  fetched instruction
out_valid  out  1  head entry is valid
out_ready  in  1  decode consumes the head this cycle
pc_out  out  PC_W  head pc; 0 when empty
instr_out  out  INSTR_W  head instruction; 0 (NOP) when empty
count  out  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- State: storage array [DEPTH]; rd_ptr and wr_ptr, each log2(DEPTH)+1 bits, where the extra MSB is a wrap bit.
- empty = (rd_ptr == wr_ptr).
- full = (index bits equal) and (wrap bits differ).
- count = wr_ptr - rd_ptr, modulo 2^(log2(DEPTH)+1).
- Reset (rst=0, asynchronous):
  - rd_ptr = wr_ptr = 0, count = 0, out_valid = 0, pc_out = instr_out = 0, in_ready = 1.
  - Storage contents are don't-care and need not be reset.
  - Reset asserted mid-operation drops all entries immediately, independent of clk.
- in_ready = !full. This is combinational from state only, never from in_valid or out_ready.
- push = in_valid & in_ready & !flush. It writes the entry at wr_ptr and increments wr_ptr; the index wraps from DEPTH-1 to 0 and the wrap bit toggles.
- pop = out_valid & out_ready & !flush. It increments rd_ptr with the same wrap rule.
- out_valid = !empty. pc_out and instr_out are the head entry when non-empty, else forced to 0.
- Latency: a push into an empty queue is visible at the outputs on the cycle after the edge. There is no same-cycle bypass.
- Simultaneous push and pop (queue neither full nor empty): both happen and count is unchanged.
  - When full, no push is possible (in_ready=0), so a pop frees a slot for the next cycle only.
  - When empty, no pop is possible (out_valid=0).
- Flush = 1 at a rising edge:
  - rd_ptr and wr_ptr return to 0, count = 0.
  - Any push or pop in that cycle is discarded.
  - From the next cycle, outputs read 0 with out_valid = 0.
  - Flush has priority over push and pop regardless of in_valid, out_ready or full.
- in_valid with in_ready = 0: the entry is not stored. Fetch must hold its pc and instruction and retry.
- out_ready while empty: no effect.
- No pointer overflow or underflow is possible under any input sequence.

Optional Feature:
Macro IFQ_STATS_EN.
- Defined: adds output stall_cycles[15:0], which increments each cycle in_valid=1 and in_ready=0.
- Defined: adds output flush_count[15:0], which increments on each flush edge.
- Both counters saturate at 0xFFFF and are cleared by rst.
- Not defined: neither port nor counter exists, and all other behaviour is identical.

Decomposition:
- Shared package if_id_pkg: PC_W and INSTR_W defaults, the NOP encoding constant (8'h00), and a packed typedef if_id_entry_t {pc, instr}.
- One natural sub-module, fifo_ptr: a pointer with wrap bit, plus inc and clear inputs. It is instantiated twice, for rd_ptr and wr_ptr.

Test Plan:
1. rst=0 for 2 cycles, then release -> count=0, out_valid=0, pc_out=0, instr_out=0, in_ready=1.
2. Push {10,A5}, {11,B6}, {12,C7}, {13,D8} with out_ready=0 -> count=4, in_ready=0, pc_out=10, instr_out=A5. A fifth push {14,E9} is rejected; after draining, exactly 4 entries come out in order.
3. Hold count=2, then apply in_valid=1 and out_ready=1 for 6 cycles with pc 20..25 -> count stays 2, and outputs sequence in FIFO order across the pointer wrap.
4. Fill with 3 entries, then assert flush together with in_valid {44,77} and out_ready=1 -> next cycle count=0, out_valid=0, pc_out=0, instr_out=0. The next push {22,99} appears at the head one cycle later.
5. Assert rst=0 between clock edges with count=3 -> outputs go to 0 and count to 0 before the next edge.
6. With IFQ_STATS_EN defined: 5 cycles of in_valid while full, then 2 flushes -> stall_cycles=5, flush_count=2.
